// File: rtl/lsu_mem_ctrl.sv
// LSU to word memory: aligns, issues one access of MEM_LATENCY cycles, and extends load data; response MEM_LATENCY+1 cycles after accept (1 if misaligned).
// Backpressure: resp_ready low parks the FSM in RESP with stable outputs and no memory re-access; req_ready is high only in IDLE.
module lsu_mem_ctrl #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic        req_store,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    output logic        mem_wen,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [1:0]    off_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic          store_q;
    logic          misaligned;
    logic [3:0]    lane_mask;
    logic          last_cycle;

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] off,
                                           input logic [1:0] size, input logic uns);
        logic [31:0] lane;
        lane = d >> {off, 3'b000};
        case (size)
            2'd0:    extend = {{24{~uns & lane[7]}}, lane[7:0]};
            2'd1:    extend = {{16{~uns & lane[15]}}, lane[15:0]};
            default: extend = lane;
        endcase
    endfunction

    always_comb begin
        misaligned = 1'b0;
        lane_mask  = 4'b1111;
        case (req_size)
            2'd0: lane_mask = 4'b0001 << req_addr[1:0];
            2'd1: begin
                lane_mask  = 4'b0011 << req_addr[1:0];
                misaligned = req_addr[0];
            end
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    assign last_cycle = (cnt_q == LAST);

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_d = misaligned ? RESP : ISSUE;
            end
            ISSUE: if (last_cycle) state_d = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            off_q      <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            store_q    <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_valid  <= 1'b0;
            mem_wen    <= 1'b0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            mem_raddr  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (req_valid) begin
                    off_q      <= req_addr[1:0];
                    size_q     <= req_size;
                    uns_q      <= req_unsigned;
                    store_q    <= req_store;
                    cnt_q      <= '0;
                    resp_rdata <= '0;
                    resp_err   <= misaligned;
                    if (!misaligned) begin
                        mem_valid <= 1'b1;
                        mem_wen   <= req_store;
                        mem_waddr <= {req_addr[31:2], 2'b00};
                        mem_raddr <= {req_addr[31:2], 2'b00};
                        mem_wdata <= req_wdata << {req_addr[1:0], 3'b000};
                        mem_wmask <= req_store ? lane_mask : 4'b0000;
                    end
                end
                ISSUE: begin
                    // Write strobe is one cycle only, however long the access lasts
                    mem_wen <= 1'b0;
                    if (last_cycle) begin
                        mem_valid  <= 1'b0;
                        mem_waddr  <= '0;
                        mem_raddr  <= '0;
                        mem_wdata  <= '0;
                        mem_wmask  <= '0;
                        resp_rdata <= store_q ? 32'h0 : extend(mem_rdata, off_q, size_q, uns_q);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: if (resp_ready) begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: two instances (MEM_LATENCY 1 and 3) share a word memory model; vectors run through a scoreboard.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic        req_store = 1'b0;
    logic        resp_ready = 1'b0;

    always #5 clk = ~clk;

    logic        rv1, rv3, rr1, rr3;
    logic        q1_rdy, q3_rdy, p1_vld, p3_vld, p1_err, p3_err;
    logic [31:0] p1_dat, p3_dat;
    logic        m1_vld, m3_vld, m1_wen, m3_wen;
    logic [31:0] m1_waddr, m3_waddr, m1_wdat, m3_wdat, m1_raddr, m3_raddr, m1_rdat, m3_rdat;
    logic [3:0]  m1_mask, m3_mask;
    logic [31:0] tbmem [0:63];

    assign rv1 = req_valid & ~sel;
    assign rv3 = req_valid & sel;
    assign rr1 = resp_ready & ~sel;
    assign rr3 = resp_ready & sel;
    assign m1_rdat = tbmem[m1_raddr[7:2]];
    assign m3_rdat = tbmem[m3_raddr[7:2]];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (m1_vld && m1_wen && m1_mask[b]) tbmem[m1_waddr[7:2]][8*b +: 8] <= m1_wdat[8*b +: 8];
            if (m3_vld && m3_wen && m3_mask[b]) tbmem[m3_waddr[7:2]][8*b +: 8] <= m3_wdat[8*b +: 8];
        end
    end

    lsu_mem_ctrl #(.MEM_LATENCY(1)) dut (
        .clock(clk), .reset(rst_n), .req_valid(rv1), .req_ready(q1_rdy),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_store(req_store),
        .resp_valid(p1_vld), .resp_ready(rr1), .resp_rdata(p1_dat), .resp_err(p1_err),
        .mem_valid(m1_vld), .mem_wen(m1_wen), .mem_waddr(m1_waddr), .mem_wdata(m1_wdat),
        .mem_wmask(m1_mask), .mem_raddr(m1_raddr), .mem_rdata(m1_rdat));

    lsu_mem_ctrl #(.MEM_LATENCY(3)) dut3 (
        .clock(clk), .reset(rst_n), .req_valid(rv3), .req_ready(q3_rdy),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_store(req_store),
        .resp_valid(p3_vld), .resp_ready(rr3), .resp_rdata(p3_dat), .resp_err(p3_err),
        .mem_valid(m3_vld), .mem_wen(m3_wen), .mem_waddr(m3_waddr), .mem_wdata(m3_wdat),
        .mem_wmask(m3_mask), .mem_raddr(m3_raddr), .mem_rdata(m3_rdat));

    logic        o_rdy, o_pvld, o_perr, o_mvld, o_wen;
    logic [31:0] o_pdat, o_waddr, o_wdat, o_raddr;
    logic [3:0]  o_mask;
    assign o_rdy   = sel ? q3_rdy   : q1_rdy;
    assign o_pvld  = sel ? p3_vld   : p1_vld;
    assign o_perr  = sel ? p3_err   : p1_err;
    assign o_pdat  = sel ? p3_dat   : p1_dat;
    assign o_mvld  = sel ? m3_vld   : m1_vld;
    assign o_wen   = sel ? m3_wen   : m1_wen;
    assign o_waddr = sel ? m3_waddr : m1_waddr;
    assign o_raddr = sel ? m3_raddr : m1_raddr;
    assign o_wdat  = sel ? m3_wdat  : m1_wdat;
    assign o_mask  = sel ? m3_mask  : m1_mask;

    typedef struct {
        logic        sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic        store;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [3:0]  exp_mask;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cur = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL v%0d %s: got %h want %h", cur, name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic [31:0] a, input logic [31:0] wd,
                                input logic [1:0] sz, input logic u, input logic st, input int h,
                                input logic [31:0] er, input logic ee, input logic [3:0] em,
                                input logic [31:0] ew);
        vec_t v;
        v.sel = s; v.addr = a; v.wdata = wd; v.size = sz; v.uns = u; v.store = st; v.hold = h;
        v.exp_rdata = er; v.exp_err = ee; v.exp_mask = em; v.exp_wdata = ew;
        return v;
    endfunction

    task automatic run(input vec_t v);
        int   lat, nv, nw, lmem;
        logic got, first_wen;
        logic [31:0] c_waddr, c_raddr, c_wdat;
        logic [3:0]  c_mask;
        exp_t e;
        lmem = v.sel ? 3 : 1;
        @(negedge clk);
        sel = v.sel; req_addr = v.addr; req_wdata = v.wdata; req_size = v.size;
        req_unsigned = v.uns; req_store = v.store; resp_ready = 1'b0; req_valid = 1'b1;
        sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        chk("req_ready idle", {31'b0, o_rdy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1; nv = 0; nw = 0; got = 1'b0; first_wen = 1'b0;
        c_waddr = '0; c_raddr = '0; c_wdat = '0; c_mask = '0;
        for (int c = 0; c < 20; c++) begin
            if (o_pvld) begin
                got = 1'b1;
                break;
            end
            if (o_mvld) begin
                if (nv == 0) begin
                    c_waddr = o_waddr; c_raddr = o_raddr; c_wdat = o_wdat;
                    c_mask = o_mask; first_wen = o_wen;
                end
                nv++;
            end
            if (o_wen) nw++;
            @(negedge clk);
            lat++;
        end
        chk("resp seen", {31'b0, got}, 32'd1);
        chk("latency", lat, v.exp_err ? 32'd1 : 32'(lmem + 1));
        chk("mem_valid cycles", nv, v.exp_err ? 32'd0 : 32'(lmem));
        chk("wen cycles", nw, (v.store && !v.exp_err) ? 32'd1 : 32'd0);
        if (nv > 0) begin
            chk("wen first", {31'b0, first_wen}, {31'b0, v.store});
            chk("wmask", {28'b0, c_mask}, {28'b0, v.exp_mask});
            chk("waddr", c_waddr, {v.addr[31:2], 2'b00});
            chk("raddr", c_raddr, {v.addr[31:2], 2'b00});
            if (v.store) chk("wdata", c_wdat, v.exp_wdata);
        end
        if (got) begin
            if (sb.size() == 0) begin
                chk("scoreboard empty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk("resp_rdata", o_pdat, e.rdata);
                chk("resp_err", {31'b0, o_perr}, {31'b0, e.err});
            end
        end
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk("hold resp_valid", {31'b0, o_pvld}, 32'd1);
            chk("hold rdata", o_pdat, v.exp_rdata);
            chk("hold req_ready", {31'b0, o_rdy}, 32'd0);
            chk("hold mem_valid", {31'b0, o_mvld}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk("post resp_valid", {31'b0, o_pvld}, 32'd0);
        chk("post req_ready", {31'b0, o_rdy}, 32'd1);
    endtask

    initial begin
        // sel addr wdata size uns store hold | rdata err mask wdata
        vecs.push_back(mk(0, 32'h8000_0010, 32'hDEAD_BEEF, 2, 0, 1, 0, 32'h0,         0, 4'b1111, 32'hDEAD_BEEF));
        vecs.push_back(mk(0, 32'h8000_0010, 32'h0,         2, 0, 0, 5, 32'hDEAD_BEEF, 0, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 32'h8000_0010, 32'h80AB_CDEF, 2, 0, 1, 0, 32'h0,         0, 4'b1111, 32'h80AB_CDEF));
        vecs.push_back(mk(0, 32'h8000_0013, 32'h0,         0, 0, 0, 0, 32'hFFFF_FF80, 0, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 32'h8000_0013, 32'h0,         0, 1, 0, 0, 32'h0000_0080, 0, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 32'h8000_0002, 32'h0000_1234, 1, 0, 1, 0, 32'h0,         0, 4'b1100, 32'h1234_0000));
        vecs.push_back(mk(0, 32'h8000_0002, 32'h0,         1, 0, 0, 0, 32'h0000_1234, 0, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 32'h8000_0001, 32'h0,         2, 0, 0, 0, 32'h0,         1, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 32'h8000_0003, 32'h0,         1, 0, 0, 0, 32'h0,         1, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 32'h8000_0000, 32'h5555_5555, 3, 0, 1, 2, 32'h0,         1, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 32'h8000_0011, 32'hFFFF_FFA5, 0, 0, 1, 0, 32'h0,         0, 4'b0010, 32'hFFFF_A500));
        vecs.push_back(mk(0, 32'h8000_0010, 32'h0,         1, 0, 0, 0, 32'hFFFF_A5EF, 0, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 32'h8000_0012, 32'h0,         1, 1, 0, 0, 32'h0000_80AB, 0, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 32'h8000_0010, 32'h0,         0, 0, 0, 0, 32'hFFFF_FFEF, 0, 4'b0000, 32'h0));
        vecs.push_back(mk(0, 32'h8000_0012, 32'h0,         0, 0, 0, 2, 32'hFFFF_FFAB, 0, 4'b0000, 32'h0));
        vecs.push_back(mk(1, 32'h8000_0020, 32'h1122_3344, 2, 0, 1, 0, 32'h0,         0, 4'b1111, 32'h1122_3344));
        vecs.push_back(mk(1, 32'h8000_0020, 32'h0,         2, 0, 0, 5, 32'h1122_3344, 0, 4'b0000, 32'h0));
        vecs.push_back(mk(1, 32'h8000_0021, 32'h0000_00F0, 0, 0, 1, 0, 32'h0,         0, 4'b0010, 32'h0000_F000));

        repeat (3) @(posedge clk);
        @(negedge clk);
        cur = -1;
        chk("rst req_ready",  {31'b0, q1_rdy}, 32'd1);
        chk("rst resp_valid", {31'b0, p1_vld}, 32'd0);
        chk("rst mem_valid",  {31'b0, m1_vld | m3_vld}, 32'd0);
        chk("rst mem_wen",    {31'b0, m1_wen | m3_wen}, 32'd0);
        chk("rst wmask",      {28'b0, m1_mask}, 32'd0);
        chk("rst resp_rdata", p1_dat, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cur = i;
            run(vecs[i]);
        end

        // Reset arriving while dut3 is mid-access
        cur = 100;
        @(negedge clk);
        sel = 1'b1; req_addr = 32'h8000_0020; req_size = 2'd2; req_store = 1'b0;
        req_unsigned = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort in issue", {31'b0, o_mvld}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort mem_valid", {31'b0, o_mvld}, 32'd0);
        chk("abort resp_valid", {31'b0, o_pvld}, 32'd0);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("abort no resp", {31'b0, o_pvld}, 32'd0);
        end
        chk("abort req_ready", {31'b0, o_rdy}, 32'd1);

        cur = 101;
        run(mk(1, 32'h8000_0020, 32'h0, 2, 0, 0, 0, 32'h1122_F044, 0, 4'b0000, 32'h0));
        cur = 102;
        run(mk(1, 32'h8000_0022, 32'h0, 1, 0, 0, 0, 32'h0000_1122, 0, 4'b0000, 32'h0));
        cur = 103;
        run(mk(1, 32'h8000_0021, 32'h0, 1, 0, 0, 3, 32'h0,         1, 4'b0000, 32'h0));
        cur = 104;
        chk("scoreboard drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit sitting directly upstream of the DPI data-memory model; consumes execute-stage memory requests and produces the memory's valid/write/mask/address/data strobes.
- Aligns byte/half/word accesses onto the 32-bit word memory, then sign- or zero-extends load data.
- Returns one response per request over a valid/ready handshake.
- Memory read path is combinational; the block registers all memory-side outputs.

Parameters:
- MEM_LATENCY, 1, cycles mem_valid is held per access (>=1); read data is captured on the last of these cycles.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-low reset (asserted when 0)
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_addr  input  32  byte address
- req_wdata  input  32  store data, LSB-aligned
- req_size  input  2  0=byte, 1=half, 2=word, 3=reserved (treated as misaligned)
- req_unsigned  input  1  load zero-extends when 1
- req_store  input  1  1=store, 0=load
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- resp_rdata  output  32  extended load data (0 for stores/errors)
- resp_err  output  1  misaligned/reserved-size request, no memory access made
- mem_valid  output  1  memory access strobe
- mem_wen  output  1  write enable
- mem_waddr  output  32  word-aligned write address
- mem_wdata  output  32  lane-shifted write data
- mem_wmask  output  4  byte lane mask
- mem_raddr  output  32  word-aligned read address
- mem_rdata  input  32  memory read data (combinational from mem_raddr)

Behaviour:
- Reset (reset==0 at rising edge): state=IDLE, counter=0. All outputs are 0 except req_ready=1 in IDLE.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch addr, wdata, size, unsigned, store; off=addr[1:0].
  - Misaligned (half with off[0]=1; word with off!=0; size==3): go to RESP with resp_err=1, resp_rdata=0, no mem_valid.
  - Otherwise: go to ISSUE, counter=0.
- ISSUE:
  - Lasts exactly MEM_LATENCY cycles; mem_valid=1 throughout.
  - mem_raddr=mem_waddr={addr[31:2],2'b00}.
  - mem_wen=store only in the first ISSUE cycle, so the write fires once.
  - mem_wmask: byte 4'b0001<<off; half 4'b0011<<off; word 4'b1111. mem_wmask is 0 for loads.
  - mem_wdata=wdata<<(8*off).
  - In the last cycle, capture mem_rdata, go to RESP, drop mem_valid/mem_wen next cycle.
- RESP:
  - resp_valid=1, outputs stable until resp_ready. On handshake go to IDLE.
  - req_ready=0 in this state: no same-cycle accept.
  - Load extraction: lane=rdata>>(8*off).
    - Byte: [7:0], extend bit7 unless unsigned.
    - Half: [15:0], extend bit15 unless unsigned.
    - Word: as-is.
  - Stores: resp_rdata=0, resp_err=0.
- Throughput: one request per MEM_LATENCY+2 cycles minimum.
- Backpressure: resp_ready low holds RESP indefinitely; memory is not re-accessed.
- Reset mid-ISSUE: access is aborted and mem_valid=0 from the next cycle. A write already strobed is not undone. No response is produced.
- req_* inputs are ignored outside IDLE.

Test Plan:
- Word store/load at 0x80000010, MEM_LATENCY=1:
  - Store 0xDEADBEEF gives one cycle of mem_wen=1, mask 4'b1111, waddr 0x80000010, resp_rdata=0.
  - Load returns 0xDEADBEEF, resp_valid 2 cycles after accept.
- Byte load at 0x80000013 with memory 0x80AB_CDEF: signed gives 0xFFFFFF80; unsigned gives 0x00000080; mem_raddr=0x80000010.
- Half store 0x1234 at 0x80000002: mem_wmask=4'b1100, mem_wdata=0x12340000, wen high exactly one cycle.
- Misaligned word at 0x80000001: resp_err=1, resp_valid the cycle after accept, mem_valid never asserted.
- Backpressure: resp_ready=0 for 5 cycles, so resp_valid/rdata stay stable, req_ready=0, and no extra mem_valid. MEM_LATENCY=3 gives mem_valid high 3 cycles with wen only in the first.
- Reset low during ISSUE: next cycle mem_valid=0, resp_valid=0, req_ready=1 after release, and a new load completes normally.
